// File: rtl/rob_commit_ctrl.sv
// Retirement sequencer for the 3-wide ROB: commits up to three entries per cycle and runs squash/redirect/drain recovery.
// Optional halt support is compiled in when ROB_COMMIT_HALT_EN is defined.
module rob_commit_ctrl #(
   parameter int PRW           = 6,
   parameter int XLEN          = 32,
   parameter int SQUASH_CYCLES = 2,
   parameter int CNT_W         = 32
) (
`ifdef ROB_COMMIT_HALT_EN
   input  logic [2:0]        retire_halt,
   output logic              halted,
`endif
   input  logic              clock,
   input  logic              reset,
   input  logic [2:0]        retire_valid,
   input  logic [2:0]        retire_precise,
   input  logic [3*PRW-1:0]  retire_tp,
   input  logic [3*PRW-1:0]  retire_told,
   input  logic [3*XLEN-1:0] retire_target,
   input  logic              recover_done,
   output logic [2:0]        commit_valid,
   output logic [3*PRW-1:0]  commit_tp,
   output logic [3*PRW-1:0]  commit_told,
   output logic              squash,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              dispatch_stall,
   output logic [CNT_W-1:0]  commit_count
);

   localparam int SC_W = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

   typedef enum logic [1:0] {NORMAL, SQUASH, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [SC_W-1:0]   sq_cnt_q, sq_cnt_d;
   logic [2:0]        commit_valid_q, commit_valid_d;
   logic [3*PRW-1:0]  commit_tp_q, commit_tp_d;
   logic [3*PRW-1:0]  commit_told_q, commit_told_d;
   logic              redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
   logic [CNT_W-1:0]  commit_count_q, commit_count_d;
   logic              halted_q, halted_d;

   logic [2:0] halt_in;
   logic [2:0] stop;
   logic [2:0] take;
   logic [2:0] commit;
   logic       accept;
   logic       hit_any;
   logic [1:0] hit_slot;
   logic       go_squash;
   logic       go_halt;

`ifdef ROB_COMMIT_HALT_EN
   assign halt_in = retire_halt;
   assign halted  = halted_q;
`else
   assign halt_in = 3'b000;
`endif

   always_comb begin
      stop    = retire_precise | halt_in;
      // A stopping entry commits itself but cuts off every younger slot.
      take[2] = retire_valid[2];
      take[1] = retire_valid[1] & ~(retire_valid[2] & stop[2]);
      take[0] = retire_valid[0] & ~(retire_valid[2] & stop[2]) & ~(retire_valid[1] & stop[1]);
      accept  = (state_q == NORMAL) & ~halted_q;
      commit  = take & {3{accept}};

      hit_any  = 1'b0;
      hit_slot = 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (commit[k] & stop[k]) begin
            hit_any  = 1'b1;
            hit_slot = 2'(k);
         end
      end
      go_halt   = hit_any & halt_in[hit_slot];
      go_squash = hit_any & retire_precise[hit_slot] & ~halt_in[hit_slot];
   end

   always_comb begin
      state_d          = state_q;
      sq_cnt_d         = sq_cnt_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      halted_d         = halted_q | go_halt;
      commit_valid_d   = commit;
      commit_tp_d      = '0;
      commit_told_d    = '0;
      for (int k = 0; k < 3; k++) begin
         if (commit[k]) begin
            commit_tp_d[k*PRW +: PRW]   = retire_tp[k*PRW +: PRW];
            commit_told_d[k*PRW +: PRW] = retire_told[k*PRW +: PRW];
         end
      end
      commit_count_d = commit_count_q + CNT_W'(commit[0]) + CNT_W'(commit[1]) + CNT_W'(commit[2]);

      case (state_q)
         NORMAL: begin
            if (go_squash) begin
               state_d          = SQUASH;
               sq_cnt_d         = SC_W'(SQUASH_CYCLES - 1);
               redirect_valid_d = 1'b1;
               redirect_pc_d    = retire_target[hit_slot*XLEN +: XLEN];
            end
         end
         SQUASH: begin
            if (sq_cnt_q == '0) state_d = DRAIN;
            else                sq_cnt_d = sq_cnt_q - 1'b1;
         end
         DRAIN: begin
            if (recover_done) state_d = NORMAL;
         end
         default: state_d = NORMAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= NORMAL;
         sq_cnt_q         <= '0;
         commit_valid_q   <= '0;
         commit_tp_q      <= '0;
         commit_told_q    <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         commit_count_q   <= '0;
         halted_q         <= 1'b0;
      end else begin
         state_q          <= state_d;
         sq_cnt_q         <= sq_cnt_d;
         commit_valid_q   <= commit_valid_d;
         commit_tp_q      <= commit_tp_d;
         commit_told_q    <= commit_told_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         commit_count_q   <= commit_count_d;
         halted_q         <= halted_d;
      end
   end

   // The ROB only ever retires a contiguous run starting at the oldest slot.
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (retire_valid inside {3'b000, 3'b100, 3'b110, 3'b111})
            else $fatal(1, "rob_commit_ctrl: non-contiguous retire_valid %b", retire_valid);
      end
   end

   assign commit_valid   = commit_valid_q;
   assign commit_tp      = commit_tp_q;
   assign commit_told    = commit_told_q;
   assign squash         = (state_q == SQUASH);
   assign dispatch_stall = (state_q != NORMAL);
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign commit_count   = commit_count_q;

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Sequences retirement out of the 3-wide ROB.
- Each cycle it accepts up to three retiring entries, with slot 2 the oldest. It forwards them in order to the architectural map table and free list.
- When a retired entry carries precise_state_need, it runs the recovery sequence: squash the pipeline, redirect fetch, and wait for the rename structures to restore.
- It sits between the ROB retire port and the front end, map table and free list.

Parameters:
- PRW, 6, physical register tag width
- XLEN, 32, PC width
- SQUASH_CYCLES, 2, cycles squash is held high (minimum 1)
- CNT_W, 32, committed-instruction counter width

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- retire_valid  in  3  per-slot valid from the ROB; [2] is oldest
- retire_precise  in  3  per-slot precise_state_need
- retire_tp  in  3xPRW  new physical tag per slot
- retire_told  in  3xPRW  previous physical tag per slot
- retire_target  in  3xXLEN  redirect target per slot
- recover_done  in  1  map table and free list restore complete (level)
- commit_valid  out  3  registered commit strobes, same slot order as retire_valid
- commit_tp  out  3xPRW  registered tags to the architectural map table
- commit_told  out  3xPRW  registered tags to the free list
- squash  out  1  flush all speculative state
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  XLEN  redirect target
- dispatch_stall  out  1  blocks ROB dispatch
- commit_count  out  CNT_W  total instructions committed

Behaviour:
- Reset state and outputs:
  - FSM enters NORMAL.
  - commit_valid, squash, redirect_valid, dispatch_stall are 0.
  - redirect_pc, commit_tp, commit_told, commit_count are 0.
- Retire valids are legal only as a contiguous run from slot 2 downward: 000, 100, 110, 111. Any other pattern is a fatal assertion in simulation.
- NORMAL state:
  - Slot k commits iff retire_valid[k] is set, and no older valid slot j>k has retire_precise[j] set.
  - The precise entry itself commits. Every younger slot is dropped.
  - commit_valid, commit_tp and commit_told register these values, with 1-cycle latency.
  - commit_count increments by the number committed, wrapping modulo 2^CNT_W.
- Entering SQUASH:
  - If any committed slot is precise, the oldest such slot p is used.
  - Next cycle: FSM goes to SQUASH, redirect_pc = retire_target[p], redirect_valid = 1 for exactly that cycle.
  - squash and dispatch_stall assert that same cycle.
  - A squash counter loads SQUASH_CYCLES-1.
- SQUASH state:
  - squash stays high for exactly SQUASH_CYCLES cycles.
  - retire_valid is ignored (the ROB is being cleared); commit_valid = 0.
  - When the counter reaches 0, go to DRAIN.
- DRAIN state:
  - squash = 0, dispatch_stall = 1, commit_valid = 0, retire inputs ignored.
  - When recover_done is seen high, go to NORMAL next cycle; dispatch_stall deasserts that same cycle.
  - If recover_done is already high on entry, DRAIN lasts exactly 1 cycle.
- Only the first precise entry per group triggers recovery. A second precise in a younger slot is dropped with the rest of the younger slots.
- dispatch_stall is 0 in NORMAL.
- redirect_pc holds its last value outside the redirect pulse.
- Reset asserted in any state (including mid-SQUASH) returns to NORMAL next cycle; no redirect is emitted.

Optional Feature:
- Macro: ROB_COMMIT_HALT_EN.
- When defined, the block adds an input retire_halt (3 bits) and an output halted (1 bit, sticky, cleared only by reset).
- A halt slot commits like a precise slot: younger slots are dropped. halted then sets on the next cycle, and all further commits are suppressed. No squash or redirect is issued.
- If a slot is both halt and precise, halt wins.
- When not defined, the port and the logic are absent.

Test Plan:
- Reset, then retire_valid=111 with no precise bits for 4 cycles -> commit_valid=111 one cycle after each group; commit_count=12; squash=0 throughout.
- retire_valid=111, retire_precise=010, retire_target[1]=0x1000 -> next cycle: commit_valid=110, redirect_valid=1 for 1 cycle, redirect_pc=0x1000. squash is high for SQUASH_CYCLES=2 cycles; count +=2.
- After the squash, hold recover_done=0 for 3 cycles, then 1 -> dispatch_stall stays high until the cycle after recover_done, then 0. No commits while it is high.
- retire_valid=111 during SQUASH and DRAIN -> commit_valid stays 000; commit_count unchanged.
- Assert reset during the second SQUASH cycle -> next cycle the FSM is NORMAL, squash=0, dispatch_stall=0, commit_count=0.
- ROB_COMMIT_HALT_EN defined: retire_valid=111, retire_halt=100 -> commit_valid=100, then halted=1. A later group of 111 produces no commits.
